mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the single-cycle CPU; executes MIPS-style mult, multu, div and divu over 32 cycles using one shared adder/subtractor and shift registers.
- Owns the HI/LO architectural registers and supports mthi/mtlo writes.
- Sits beside the combinational ALU. Control stalls the pipeline on busy and reads hi/lo for mfhi/mflo.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported by the CPU.
- CNT_W, 5, iteration-counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- A  input  WIDTH  multiplicand or dividend (rs).
- B  input  WIDTH  multiplier or divisor (rt).
- hi_wr  input  1  mthi strobe.
- lo_wr  input  1  mtlo strobe.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO have just been updated by an operation.
- hi  output  WIDTH  HI register (registered).
- lo  output  WIDTH  LO register (registered).

Behaviour:
- Reset (synchronous, active-high): on the edge with reset=1 → state IDLE, counter=0, busy=0, done=0, hi=0, lo=0. This takes effect mid-operation as well; the partial result is discarded.
- States: IDLE → CALC → FIX → IDLE.
- IDLE:
  - If start=1, latch A, B and op. For signed ops, also latch operand signs and absolute values (|0x80000000| = 0x80000000 as unsigned). Go to CALC with counter=0 and busy=1 from the next cycle.
  - start has priority over hi_wr/lo_wr in the same cycle; the writes are dropped.
  - With start=0, hi_wr/lo_wr load wdata into hi/lo on the edge. Both strobes may be set in one cycle.
- CALC: runs exactly 32 cycles (counter 0..31), one shift plus add or subtract per cycle.
  - Multiply: shift-add on the 64-bit product register {P_hi, P_lo}.
  - Divide: restoring division, shifting the remainder/quotient pair. The quotient bit is 1 if the trial remainder is ≥ 0.
  - Counter wraps from 31 to FIX.
- FIX: one cycle.
  - mult: negate the 64-bit product if the operand signs differ.
  - div: negate the quotient if the signs differ; the remainder takes the dividend's sign (truncate toward zero).
  - Write hi/lo, go to IDLE. done=1 and busy=0 in the following cycle.
- Latency: start accepted on edge N; busy=1 in cycles N+1..N+33; done=1 and new hi/lo visible in cycle N+34. The next start may be accepted in cycle N+34.
- start while busy=1 is ignored; no queueing.
- hi_wr/lo_wr while busy=1 are ignored.
- hi/lo hold the old values until FIX completes. No partial results are ever visible.
- Divide by zero:
  - No trap; latency is unchanged.
  - divu: lo=0xFFFFFFFF, hi=A.
  - div: lo=0xFFFFFFFF if A ≥ 0, else 0x00000001; hi=A.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This matches the unsigned-magnitude algorithm plus FIX negation, with no special case needed.
- Product width: the full 64 bits are kept (hi = upper, lo = lower). No overflow flag.
- done is deasserted in all cycles other than the single pulse.

Test Plan:
- Reset then multu:
  - Stimulus: reset=1 for 2 cycles, then multu A=0xFFFFFFFF, B=0xFFFFFFFF.
  - Required: hi=0/lo=0/busy=0 after reset; done in cycle N+34 with hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- Signed multiply: mult A=0xFFFFFFFD (-3), B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then mult A=0x80000000, B=0x80000000 → hi=0x40000000, lo=0.
- Divide:
  - divu A=7, B=2 → lo=3, hi=1.
  - div A=0xFFFFFFF9 (-7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div A=7, B=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- Boundaries:
  - divu A=5, B=0 → lo=0xFFFFFFFF, hi=5.
  - div A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0. done in the same cycle position as a normal divide.
- Interference during an operation:
  - Start multu 3×4. At cycle N+5 pulse start with op=divu and pulse hi_wr with wdata=0xDEAD0000 → both ignored; final hi=0, lo=12.
  - In IDLE, set start and lo_wr together → the operation runs and the lo_wr is dropped.
  - In IDLE, hi_wr=1 with wdata=0x12345678 → hi=0x12345678 next cycle, done stays 0.
- Reset mid-operation: start mult; assert reset at cycle N+10 → next cycle busy=0, hi=0, lo=0, done never pulses. A fresh multu 2×3 then completes in 34 cycles with lo=6.

Source files
------------

// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq -- iterative multiply/divide unit that owns the HI/LO registers.
//
// This unit runs mult, multu, div and divu as 32 shift-and-add or
// shift-and-subtract steps. All four operations share one adder/subtractor.
// Signed operations work on operand magnitudes. A single FIX cycle then
// applies the result signs and writes HI/LO in one step, so a partially
// computed result never reaches hi/lo.
//
// Ports
//   clk     : system clock; all state changes on the rising edge
//   reset   : synchronous, active-high reset; aborts any operation in flight
//   start   : launch op with operands A/B (sampled only while idle)
//   op      : 00 multu, 01 mult, 10 divu, 11 div
//   A, B    : multiplicand/multiplier or dividend/divisor
//   hi_wr   : mthi strobe (idle only; dropped if start is also high)
//   lo_wr   : mtlo strobe (idle only; dropped if start is also high)
//   wdata   : data for mthi/mtlo
//   busy    : operation in flight
//   done    : one-cycle pulse in the cycle where new HI/LO are first visible
//   hi, lo  : architectural HI/LO registers
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Two guard bits: one for the multiply carry-out, one for the divide borrow.
    localparam int DW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // m holds the adder operand that stays fixed during CALC:
    // the multiplicand for a multiply, the divisor for a divide.
    logic [WIDTH-1:0]   m_q, m_d;
    // p_hi is the product high half or the partial remainder.
    // p_lo is the multiplier being shifted out, or the dividend being
    // shifted out while quotient bits are shifted in.
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;        // operand signs differ
    logic               sign_a_q, sign_a_d;  // dividend sign, used for the remainder
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [DW-1:0]      add_x, add_y, add_sum;
    logic               add_sub;
    logic [2*WIDTH-1:0] prod_neg;

    // Signs count only for signed ops. Negating 0x80000000 gives back
    // 0x80000000, which is the correct magnitude when read as unsigned.
    assign a_neg = op[0] & A[WIDTH-1];
    assign b_neg = op[0] & B[WIDTH-1];
    assign a_abs = a_neg ? -A : A;
    assign b_abs = b_neg ? -B : B;

    assign prod_neg = -{p_hi_q, p_lo_q};

    // Shared adder/subtractor.
    // Divide: trial subtraction of the divisor from {rem, next dividend bit}.
    //   Bit DW-1 of the result is the borrow, so 0 means trial >= 0.
    // Multiply: add the multiplicand when the current multiplier bit is 1.
    always_comb begin
        if (is_div_q) begin
            add_x   = {1'b0, p_hi_q, p_lo_q[WIDTH-1]};
            add_y   = {2'b00, m_q};
            add_sub = 1'b1;
        end else begin
            add_x   = {2'b00, p_hi_q};
            add_y   = p_lo_q[0] ? {2'b00, m_q} : '0;
            add_sub = 1'b0;
        end
        add_sum = add_x + (add_sub ? ~add_y : add_y) + {{(DW-1){1'b0}}, add_sub};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    sign_a_d = a_neg;
                    m_d      = op[1] ? b_abs : a_abs;
                    p_lo_d   = op[1] ? a_abs : b_abs;
                    p_hi_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end else begin
                    if (hi_wr) hi_d = wdata;
                    if (lo_wr) lo_d = wdata;
                end
            end

            CALC: begin
                if (is_div_q) begin
                    // Restoring division: keep the shifted remainder on a borrow.
                    p_hi_d = add_sum[DW-1] ? {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]}
                                           : add_sum[WIDTH-1:0];
                    p_lo_d = {p_lo_q[WIDTH-2:0], ~add_sum[DW-1]};
                end else begin
                    // Shift the 65-bit {carry, P_hi, P_lo} right by one.
                    p_hi_d = add_sum[WIDTH:1];
                    p_lo_d = {add_sum[0], p_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q    ? -p_lo_q : p_lo_q;
                    hi_d = sign_a_q ? -p_hi_q : p_hi_q;
                end else begin
                    {hi_d, lo_d} = neg_q ? prod_neg : {p_hi_q, p_lo_q};
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// -----------------------------------------------------------------------------
// tb_mdu_seq -- self-checking bench for mdu_seq.
// Directed steps cover reset, mthi/mtlo, interference and the divide corner
// cases. A randomized loop follows, and every result is checked against a
// 64-bit arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset, start, hi_wr, lo_wr;
    logic [1:0]  op;
    logic [31:0] a_in, b_in, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a_in),
        .B     (b_in),
        .hi_wr (hi_wr),
        .lo_wr (lo_wr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'h0;
        case (o)
            2'b00: res = {32'h0, a} * {32'h0, b};
            2'b01: begin
                p   = sa * sb;
                res = p;
            end
            2'b10: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
            default: begin
                if (b == 32'h0) begin
                    res = {a, (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Launch one operation and follow it for 36 cycles.
    // If intf_k > 0, a stray start (divu) plus an mthi pulse is driven in cycle N+intf_k.
    // If with_lo_wr is set, mtlo is raised in the same cycle as start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int intf_k, input logic with_lo_wr);
        logic [63:0] expv;
        int          busy_cnt, done_cnt, done_k;
        logic        changed;
        logic [31:0] hi34, lo34;
        expv     = ref_model(o, a, b);
        busy_cnt = 0;
        done_cnt = 0;
        done_k   = 0;
        changed  = 1'b0;
        hi34     = 32'hx;
        lo34     = 32'hx;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        lo_wr = with_lo_wr; wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        start = 1'b0; lo_wr = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_k = k; end
            if (k <= 33 && (hi !== exp_hi || lo !== exp_lo)) changed = 1'b1;
            if (k == 34) begin hi34 = hi; lo34 = lo; end
            if (intf_k > 0 && k == intf_k) begin
                start = 1'b1; op = 2'b10; hi_wr = 1'b1; wdata = 32'hDEAD_0000;
            end else if (intf_k > 0 && k == intf_k + 1) begin
                start = 1'b0; hi_wr = 1'b0;
            end
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_cycle"},  64'(done_k),   64'd34);
        check({tag, "_hilo_held"},   64'(changed),  64'd0);
        check({tag, "_hi"}, {32'h0, hi34}, {32'h0, expv[63:32]});
        check({tag, "_lo"}, {32'h0, lo34}, {32'h0, expv[31:0]});
        $display("op=%0d A=%h B=%h -> hi=%h lo=%h (model %h %h)",
                 o, a, b, hi34, lo34, expv[63:32], expv[31:0]);
        exp_hi = expv[63:32];
        exp_lo = expv[31:0];
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          dcnt;

        reset = 1'b1; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        op = 2'b00; a_in = 32'h0; b_in = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_hi",   {32'h0, hi}, 64'h0);
        check("reset_lo",   {32'h0, lo}, 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);

        run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg",   2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0);
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        check("mult_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op("divu_7_2",   2'b10, 32'h7, 32'h2, 0, 1'b0);
        check("divu_7_2_const", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op("div_n7_2",   2'b11, 32'hFFFF_FFF9, 32'h2, 0, 1'b0);
        check("div_n7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_7_n2",   2'b11, 32'h7, 32'hFFFF_FFFE, 0, 1'b0);
        check("div_7_n2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        run_op("divu_by0",   2'b10, 32'h5, 32'h0, 0, 1'b0);
        check("divu_by0_const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        run_op("div_by0_neg", 2'b11, 32'hFFFF_FFF0, 32'h0, 0, 1'b0);
        check("div_by0_neg_const", {hi, lo}, 64'hFFFF_FFF0_0000_0001);
        run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // Stray start and mthi while busy: both must be ignored.
        run_op("multu_intf", 2'b00, 32'h3, 32'h4, 5, 1'b0);
        check("multu_intf_const", {hi, lo}, 64'h0000_0000_0000_000C);
        check("intf_no_restart", 64'(busy), 64'h0);

        // start together with mtlo: the operation wins and the write is dropped.
        run_op("start_lo_wr", 2'b10, 32'd100, 32'd7, 0, 1'b1);
        check("start_lo_wr_const", {hi, lo}, 64'h0000_0002_0000_000E);

        // mthi alone in idle.
        @(negedge clk);
        hi_wr = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_wr = 1'b0;
        check("mthi_hi",   {32'h0, hi}, 64'h0000_0000_1234_5678);
        check("mthi_lo",   {32'h0, lo}, {32'h0, exp_lo});
        check("mthi_done", 64'(done), 64'h0);
        exp_hi = 32'h1234_5678;

        // mthi and mtlo in the same cycle.
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("mthilo_hi", {32'h0, hi}, 64'h0000_0000_CAFE_F00D);
        check("mthilo_lo", {32'h0, lo}, 64'h0000_0000_CAFE_F00D);
        exp_hi = 32'hCAFE_F00D;
        exp_lo = 32'hCAFE_F00D;

        // Reset in the middle of a mult.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a_in = 32'hFFFF_1234; b_in = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_hi",   {32'h0, hi}, 64'h0);
        check("midrst_lo",   {32'h0, lo}, 64'h0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        check("midrst_quiet", 64'(dcnt), 64'h0);
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        run_op("post_rst", 2'b00, 32'h2, 32'h3, 0, 1'b0);
        check("post_rst_const", {hi, lo}, 64'h0000_0000_0000_0006);

        // Randomized operations with occasional corner operands.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", ro, ra, rb, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
